dmem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single data memory between requester 0 (CPU load/store unit) and requester 1 (loader/debug port). Sits directly in front of the data memory and owns its write-enable, byte-mode, address and write-data inputs. Every access is sequenced through a two-state FSM, and each access gets a registered one-cycle completion pulse carrying the read data.

---
 rtl/dmem_arbiter_if.sv | 41 ++++
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester and data-memory signals around dmem_arbiter.
// The slave side is the arbiter; the master side drives requests and supplies memory read data.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              i_Arb_req0;
    logic              i_Arb_req1;
    logic              i_Arb_we0;
    logic              i_Arb_we1;
    logic              i_Arb_sByte0;
    logic              i_Arb_sByte1;
    logic [DATA_W-1:0] i_Arb_addr0;
    logic [DATA_W-1:0] i_Arb_addr1;
    logic [DATA_W-1:0] i_Arb_wData0;
    logic [DATA_W-1:0] i_Arb_wData1;
    logic              o_Arb_done0;
    logic              o_Arb_done1;
    logic [DATA_W-1:0] o_Arb_rData;
    logic              o_Arb_busy;
    logic              o_DMem_dMemWe;
    logic              o_DMem_sByte;
    logic [DATA_W-1:0] o_DMem_addr;
    logic [DATA_W-1:0] o_DMem_wData;
    logic [DATA_W-1:0] i_DMem_rData;

    modport slave (
        input  i_Arb_req0, i_Arb_req1, i_Arb_we0, i_Arb_we1,
        input  i_Arb_sByte0, i_Arb_sByte1, i_Arb_addr0, i_Arb_addr1,
        input  i_Arb_wData0, i_Arb_wData1, i_DMem_rData,
        output o_Arb_done0, o_Arb_done1, o_Arb_rData, o_Arb_busy,
        output o_DMem_dMemWe, o_DMem_sByte, o_DMem_addr, o_DMem_wData
    );

    modport master (
        output i_Arb_req0, i_Arb_req1, i_Arb_we0, i_Arb_we1,
        output i_Arb_sByte0, i_Arb_sByte1, i_Arb_addr0, i_Arb_addr1,
        output i_Arb_wData0, i_Arb_wData1, i_DMem_rData,
        input  o_Arb_done0, o_Arb_done1, o_Arb_rData, o_Arb_busy,
        input  o_DMem_dMemWe, o_DMem_sByte, o_DMem_addr, o_DMem_wData
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU LSU (port 0) and loader/debug (port 1).
// Each access: grant in IDLE, one ACCESS cycle driving the memory, registered done pulse with read data.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | memory write disabled; arbitrate among eligible requests
//   ST_ACCESS | latched command drives the memory for exactly one cycle
module dmem_arbiter #(
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           rstn,
    dmem_arbiter_if.slave arb
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_last_gnt;
    logic              r_gnt_id;
    logic              r_cmd_we;
    logic              r_cmd_sbyte;
    logic [DATA_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_done0;
    logic              r_done1;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant;
    logic              w_win;
    logic              w_sel_we;
    logic              w_sel_sbyte;
    logic [DATA_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_busy;

    // A request still held during its own done cycle must not win a second time.
    assign w_elig0 = arb.i_Arb_req0 & ~r_done0;
    assign w_elig1 = arb.i_Arb_req1 & ~r_done1;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_win       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_elig0 && w_elig1) begin
                    w_grant = 1'b1;
                    w_win   = ~r_last_gnt;
                end else if (w_elig0) begin
                    w_grant = 1'b1;
                    w_win   = 1'b0;
                end else if (w_elig1) begin
                    w_grant = 1'b1;
                    w_win   = 1'b1;
                end
                if (w_grant) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_sel_we    = arb.i_Arb_we0;
        w_sel_sbyte = arb.i_Arb_sByte0;
        w_sel_addr  = arb.i_Arb_addr0;
        w_sel_wdata = arb.i_Arb_wData0;
        if (w_win) begin
            w_sel_we    = arb.i_Arb_we1;
            w_sel_sbyte = arb.i_Arb_sByte1;
            w_sel_addr  = arb.i_Arb_addr1;
            w_sel_wdata = arb.i_Arb_wData1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // last_gnt resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_gnt  <= 1'b1;
            r_gnt_id    <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_sbyte <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else if (w_grant) begin
            r_last_gnt  <= w_win;
            r_gnt_id    <= w_win;
            r_cmd_we    <= w_sel_we;
            r_cmd_sbyte <= w_sel_sbyte;
            r_cmd_addr  <= w_sel_addr;
            r_cmd_wdata <= w_sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (r_state == ST_ACCESS) begin
                r_rdata <= arb.i_DMem_rData;
                if (r_gnt_id) begin
                    r_done1 <= 1'b1;
                end else begin
                    r_done0 <= 1'b1;
                end
            end
        end
    end

    // Write enable decodes straight from state so an async reset kills it within the cycle.
    assign w_busy            = (r_state == ST_ACCESS);
    assign arb.o_Arb_busy    = w_busy;
    assign arb.o_DMem_dMemWe = w_busy & r_cmd_we;
    assign arb.o_DMem_sByte  = r_cmd_sbyte;
    assign arb.o_DMem_addr   = r_cmd_addr;
    assign arb.o_DMem_wData  = r_cmd_wdata;
    assign arb.o_Arb_done0   = r_done0;
    assign arb.o_Arb_done1   = r_done1;
    assign arb.o_Arb_rData   = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory, a timestamp-based
// reference model compared every cycle, and literal expectations for key results.
module tb_dmem_arbiter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_we   = 0;
    int   n_done0 = 0;
    int   order[$];

    dmem_arbiter_if #(.DATA_W(32)) bus();

    dmem_arbiter #(.DATA_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .arb  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Device memory: 256 bytes, little-endian, word accesses aligned down, byte reads zero-extended.
    logic [7:0] mem [256];
    bit         mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            mem_ready <= 1'b1;
        end else if (bus.o_DMem_dMemWe) begin
            if (bus.o_DMem_sByte) begin
                mem[bus.o_DMem_addr[7:0]] <= bus.o_DMem_wData[7:0];
            end else begin
                mem[{bus.o_DMem_addr[7:2], 2'b00}] <= bus.o_DMem_wData[7:0];
                mem[{bus.o_DMem_addr[7:2], 2'b01}] <= bus.o_DMem_wData[15:8];
                mem[{bus.o_DMem_addr[7:2], 2'b10}] <= bus.o_DMem_wData[23:16];
                mem[{bus.o_DMem_addr[7:2], 2'b11}] <= bus.o_DMem_wData[31:24];
            end
        end
    end

    always_comb begin
        if (bus.o_DMem_sByte) begin
            bus.i_DMem_rData = {24'h0, mem[bus.o_DMem_addr[7:0]]};
        end else begin
            bus.i_DMem_rData = {mem[{bus.o_DMem_addr[7:2], 2'b11}], mem[{bus.o_DMem_addr[7:2], 2'b10}],
                                mem[{bus.o_DMem_addr[7:2], 2'b01}], mem[{bus.o_DMem_addr[7:2], 2'b00}]};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: an access granted at cycle n occupies the memory at n+1 and reports done at n+2.
    logic [7:0]  gold [256];
    int          m_acc;
    int          m_done [2];
    logic        m_last, m_we, m_sb;
    logic [31:0] m_addr, m_wd, m_rdata;

    function automatic logic [31:0] gold_rd(input logic sb, input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        if (sb) return {24'h0, gold[a[7:0]]};
        return {gold[b + 8'd3], gold[b + 8'd2], gold[b + 8'd1], gold[b]};
    endfunction

    initial begin
        bit e0, e1;
        int w;
        logic [7:0] b;
        for (int i = 0; i < 256; i++) gold[i] = 8'(i);
        m_acc = -1; m_done[0] = -1; m_done[1] = -1;
        m_last = 1'b1; m_we = 1'b0; m_sb = 1'b0; m_addr = '0; m_wd = '0; m_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_acc = -1; m_done[0] = -1; m_done[1] = -1;
                m_last = 1'b1; m_we = 1'b0; m_sb = 1'b0; m_addr = '0; m_wd = '0; m_rdata = '0;
            end
            chk("busy",   32'(bus.o_Arb_busy),    32'(m_acc == cyc));
            chk("dMemWe", 32'(bus.o_DMem_dMemWe), 32'((m_acc == cyc) && m_we));
            chk("done0",  32'(bus.o_Arb_done0),   32'(m_done[0] == cyc));
            chk("done1",  32'(bus.o_Arb_done1),   32'(m_done[1] == cyc));
            chk("rData",  bus.o_Arb_rData,        m_rdata);
            chk("addr",   bus.o_DMem_addr,        m_addr);
            chk("wData",  bus.o_DMem_wData,       m_wd);
            chk("sByte",  32'(bus.o_DMem_sByte),  32'(m_sb));
            if (bus.o_DMem_dMemWe) n_we++;
            if (bus.o_Arb_done0) begin order.push_back(0); n_done0++; end
            if (bus.o_Arb_done1) order.push_back(1);
            if (rstn) begin
                if (m_acc == cyc) begin
                    m_rdata = gold_rd(m_sb, m_addr);
                    if (m_we) begin
                        if (m_sb) gold[m_addr[7:0]] = m_wd[7:0];
                        else begin
                            b = {m_addr[7:2], 2'b00};
                            gold[b] = m_wd[7:0];         gold[b + 8'd1] = m_wd[15:8];
                            gold[b + 8'd2] = m_wd[23:16]; gold[b + 8'd3] = m_wd[31:24];
                        end
                    end
                end else begin
                    e0 = bus.i_Arb_req0 && (m_done[0] != cyc);
                    e1 = bus.i_Arb_req1 && (m_done[1] != cyc);
                    if (e0 || e1) begin
                        if (e0 && e1) w = m_last ? 0 : 1;
                        else          w = e1 ? 1 : 0;
                        if (w == 0) begin
                            m_we = bus.i_Arb_we0; m_sb = bus.i_Arb_sByte0; m_addr = bus.i_Arb_addr0; m_wd = bus.i_Arb_wData0;
                        end else begin
                            m_we = bus.i_Arb_we1; m_sb = bus.i_Arb_sByte1; m_addr = bus.i_Arb_addr1; m_wd = bus.i_Arb_wData1;
                        end
                        m_last = (w == 1);
                        m_acc = cyc + 1;
                        m_done[w] = cyc + 2;
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns cycles from request to done and the rData seen with done.
    task automatic issue(input int p, input logic we, input logic sb, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold, output int lat, output logic [31:0] rd);
        int t0;
        bit got;
        t0 = cyc;
        got = 1'b0;
        if (p == 0) begin
            bus.i_Arb_req0 = 1'b1; bus.i_Arb_we0 = we; bus.i_Arb_sByte0 = sb;
            bus.i_Arb_addr0 = addr; bus.i_Arb_wData0 = wd;
        end else begin
            bus.i_Arb_req1 = 1'b1; bus.i_Arb_we1 = we; bus.i_Arb_sByte1 = sb;
            bus.i_Arb_addr1 = addr; bus.i_Arb_wData1 = wd;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if ((p == 0) ? bus.o_Arb_done0 : bus.o_Arb_done1) got = 1'b1;
        end
        if (got) begin
            lat = cyc - t0;
            rd  = bus.o_Arb_rData;
        end else begin
            lat = -1;
            rd  = 'x;
            n_vec++;
            n_miss++;
            $display("FAIL timeout port%0d: no done within 20 cycles, required one", p);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (p == 0) bus.i_Arb_req0 = 1'b0;
            else        bus.i_Arb_req1 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat0, lat1, we_snap, d_snap;
        logic [31:0] rd, rd0, rd1;
        bus.i_Arb_req0 = 1'b0; bus.i_Arb_we0 = 1'b0; bus.i_Arb_sByte0 = 1'b0;
        bus.i_Arb_addr0 = '0;  bus.i_Arb_wData0 = '0;
        bus.i_Arb_req1 = 1'b0; bus.i_Arb_we1 = 1'b0; bus.i_Arb_sByte1 = 1'b0;
        bus.i_Arb_addr1 = '0;  bus.i_Arb_wData1 = '0;

        // Reset values, then ten idle cycles.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  32'(bus.o_Arb_busy), 32'd0);
        chk("rst_we",    32'(bus.o_DMem_dMemWe), 32'd0);
        chk("rst_done",  32'({bus.o_Arb_done1, bus.o_Arb_done0}), 32'd0);
        chk("rst_rdata", bus.o_Arb_rData, 32'd0);
        chk("rst_addr",  bus.o_DMem_addr, 32'd0);
        rstn = 1'b1;
        we_snap = n_we;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_we_cycles", 32'(n_we - we_snap), 32'd0);

        // Word write then read on port 0.
        we_snap = n_we;
        issue(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, lat, rd);
        chk("wr_latency", 32'(lat), 32'd2);
        chk("wr_we_cycles", 32'(n_we - we_snap), 32'd1);
        issue(0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_word", rd, 32'hDEADBEEF);

        // Byte write through port 1, then reads.
        issue(1, 1'b1, 1'b1, 32'h11, 32'h0000005A, 1'b0, lat, rd);
        issue(0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd);
        chk("rd_after_byte", rd, 32'hDEAD5AEF);
        issue(1, 1'b0, 1'b1, 32'h11, 32'h0, 1'b0, lat, rd);
        chk("rd_byte", rd, 32'h0000005A);

        // Simultaneous requests straight out of reset.
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        order.delete();
        fork
            issue(0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat0, rd0);
            issue(1, 1'b0, 1'b0, 32'h14, 32'h0, 1'b0, lat1, rd1);
        join
        chk("sim_lat0", 32'(lat0), 32'd2);
        chk("sim_lat1", 32'(lat1), 32'd4);
        chk("sim_rd0", rd0, 32'hDEAD5AEF);
        chk("sim_rd1", rd1, 32'h17161514);
        chk("sim_order_len", 32'(order.size()), 32'd2);

        // Fairness: both held for four accesses each; port 1 reads what port 0 just wrote.
        order.delete();
        fork
            begin
                int l;
                logic [31:0] r;
                for (int k = 0; k < 4; k++)
                    issue(0, 1'b1, 1'b0, 32'h40 + 32'(4 * k), 32'hA0000000 + 32'(k), k < 3, l, r);
            end
            begin
                int l;
                logic [31:0] r;
                for (int k = 0; k < 4; k++) begin
                    issue(1, 1'b0, 1'b0, 32'h40 + 32'(4 * k), 32'h0, k < 3, l, r);
                    chk("fair_rd", r, 32'hA0000000 + 32'(k));
                end
            end
        join
        chk("fair_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < order.size(); i++) chk("fair_order", 32'(order[i]), 32'(i % 2));

        // Reset pulled during the ACCESS cycle of a write.
        bus.i_Arb_req0 = 1'b1; bus.i_Arb_we0 = 1'b1; bus.i_Arb_sByte0 = 1'b0;
        bus.i_Arb_addr0 = 32'h20; bus.i_Arb_wData0 = 32'h12345678;
        @(posedge clk);
        #2;
        chk("acc_busy", 32'(bus.o_Arb_busy), 32'd1);
        chk("acc_we",   32'(bus.o_DMem_dMemWe), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_mid_we",   32'(bus.o_DMem_dMemWe), 32'd0);
        chk("rst_mid_busy", 32'(bus.o_Arb_busy), 32'd0);
        bus.i_Arb_req0 = 1'b0; bus.i_Arb_we0 = 1'b0;
        d_snap = n_done0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_done0", 32'(n_done0 - d_snap), 32'd0);
        issue(0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, lat, rd);
        chk("rst_old_data", rd, 32'h23222120);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
